// File: rtl/agen_issue_arbiter.sv
// agen_issue_arbiter: shares one AGEN_ALU between the load and store issue lanes.
// Loads win by default. The result is held in a one-entry valid/ready output stage.
// Optional feature macro: AGEN_ARB_STARVE_GUARD_EN. When defined, a starvation
// FSM forces a store through after STARVE_LIMIT cycles of being passed over.
// When undefined, load priority is strict.

`ifndef AGEN_ISSUE_ARBITER_TYPES
`define AGEN_ISSUE_ARBITER_TYPES
`define SIZE_DATA 64
`define SIZE_IMMEDIATE 32
`define SIZE_INSTRUCTION 32
`define LDST_TYPES_LOG 2
`define LDST_BYTE 2'd0
`define LDST_HALF_WORD 2'd1
`define LDST_WORD 2'd2
`define LDST_DOUBLE_WORD 2'd3
typedef struct packed {
  logic executed;
  logic ldSign;
  logic exception;
} exeFlgs;
`endif

module agen_issue_arbiter #(
  parameter int unsigned DATA_W       = `SIZE_DATA,
  parameter int unsigned TAG_W        = 7,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush_i,
  input  logic                           ld_valid_i,
  output logic                           ld_ready_o,
  input  logic [DATA_W-1:0]              ld_data1_i,
  input  logic [`SIZE_IMMEDIATE-1:0]     ld_immd_i,
  input  logic [`SIZE_INSTRUCTION-1:0]   ld_inst_i,
  input  logic [TAG_W-1:0]               ld_tag_i,
  input  logic                           st_valid_i,
  output logic                           st_ready_o,
  input  logic [DATA_W-1:0]              st_data1_i,
  input  logic [DATA_W-1:0]              st_data2_i,
  input  logic [`SIZE_IMMEDIATE-1:0]     st_immd_i,
  input  logic [`SIZE_INSTRUCTION-1:0]   st_inst_i,
  input  logic [TAG_W-1:0]               st_tag_i,
  output logic [DATA_W-1:0]              agen_data1_o,
  output logic [DATA_W-1:0]              agen_data2_o,
  output logic [`SIZE_IMMEDIATE-1:0]     agen_immd_o,
  output logic [`SIZE_INSTRUCTION-1:0]   agen_inst_o,
  input  logic [DATA_W-1:0]              agen_address_i,
  input  logic [`LDST_TYPES_LOG-1:0]     agen_ldstSize_i,
  input  exeFlgs                         agen_flags_i,
  output logic                           mem_valid_o,
  input  logic                           mem_ready_i,
  output logic [DATA_W-1:0]              mem_address_o,
  output logic [`LDST_TYPES_LOG-1:0]     mem_size_o,
  output exeFlgs                         mem_flags_o,
  output logic [TAG_W-1:0]               mem_tag_o,
  output logic                           mem_is_store_o,
  output logic [DATA_W-1:0]              mem_stdata_o
);

  // A zero limit would make the guard meaningless.
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic slot_free;
  logic can_grant;
  logic prefer_st;
  logic grant_ld;
  logic grant_st;

  assign slot_free = !mem_valid_o || mem_ready_i;
  assign can_grant = slot_free && !flush_i;

`ifdef AGEN_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0] LD_PRI   = 1'b0;
  localparam logic [0:0] ST_FORCE = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;

  assign prefer_st = (state == ST_FORCE);

  // Starvation FSM state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LD_PRI;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Count passed-over store cycles; force the store once the limit is hit.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    if (flush_i) begin
      state_next      = LD_PRI;
      starve_cnt_next = '0;
    end else begin
      case (state)
        LD_PRI: begin
          if (grant_st) begin
            starve_cnt_next = '0;
          end else if (st_valid_i && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_next = starve_cnt + CNT_W'(1);
          end
          if (starve_cnt_next == CNT_W'(STARVE_LIMIT)) begin
            state_next = ST_FORCE;
          end
        end
        ST_FORCE: begin
          if (grant_st || !st_valid_i) begin
            state_next      = LD_PRI;
            starve_cnt_next = '0;
          end
        end
        default: begin
          state_next      = LD_PRI;
          starve_cnt_next = '0;
        end
      endcase
    end
  end
`else
  assign prefer_st = 1'b0;
`endif

  // Pick at most one lane; the preferred lane wins when both are valid.
  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (can_grant) begin
      if (prefer_st) begin
        grant_st = st_valid_i;
        grant_ld = ld_valid_i && !st_valid_i;
      end else begin
        grant_ld = ld_valid_i;
        grant_st = st_valid_i && !ld_valid_i;
      end
    end
  end

  assign ld_ready_o = grant_ld;
  assign st_ready_o = grant_st;

  // Steer operands into AGEN; the load lane is the idle default.
  assign agen_data1_o = grant_st ? st_data1_i : ld_data1_i;
  assign agen_data2_o = grant_st ? st_data2_i : '0;
  assign agen_immd_o  = grant_st ? st_immd_i  : ld_immd_i;
  assign agen_inst_o  = grant_st ? st_inst_i  : ld_inst_i;

  // One-entry output stage: flush kills, grant refills, ready drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_valid_o    <= 1'b0;
      mem_address_o  <= '0;
      mem_size_o     <= '0;
      mem_flags_o    <= '0;
      mem_tag_o      <= '0;
      mem_is_store_o <= 1'b0;
      mem_stdata_o   <= '0;
    end else if (flush_i) begin
      mem_valid_o <= 1'b0;
    end else if (grant_ld || grant_st) begin
      mem_valid_o    <= 1'b1;
      mem_address_o  <= agen_address_i;
      mem_size_o     <= agen_ldstSize_i;
      mem_flags_o    <= agen_flags_i;
      mem_tag_o      <= grant_st ? st_tag_i : ld_tag_i;
      mem_is_store_o <= grant_st;
      mem_stdata_o   <= grant_st ? st_data2_i : '0;
    end else if (mem_ready_i) begin
      mem_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/agen_issue_arbiter.md
# agen_issue_arbiter

Shares one combinational AGEN_ALU between the load issue lane and the store issue lane of the memory execute pipe. Each cycle it grants at most one requester, steers that lane's operands into the AGEN datapath, and registers the computed address, access size and flags in a one-entry output stage. The output stage has a valid/ready handshake toward the LSU. Loads have priority; a configurable starvation guard bounds how long a store can wait.

## Interface
- `DATA_W`, default `SIZE_DATA`: operand and address width.
- `TAG_W`, default 7: instruction tag width (physical destination / LSQ index).
- `STARVE_LIMIT`, default 8: number of cycles a valid store may be passed over before it is forced through.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  pipeline flush; kills the held result and blocks grants in the same cycle.
- `ld_valid_i`  in  1 / `ld_ready_o`  out  1  load lane handshake.
- `ld_data1_i`  in  DATA_W, `ld_immd_i`  in  `SIZE_IMMEDIATE`, `ld_inst_i`  in  `SIZE_INSTRUCTION`, `ld_tag_i`  in  TAG_W  load operands.
- `st_valid_i`  in  1 / `st_ready_o`  out  1  store lane handshake.
- `st_data1_i`, `st_data2_i`  in  DATA_W, `st_immd_i`, `st_inst_i`, `st_tag_i`  store operands; `data2` is the store data.
- `agen_data1_o`, `agen_data2_o`  out  DATA_W, `agen_immd_o`  out, `agen_inst_o`  out  combinational operands to AGEN_ALU.
- `agen_address_i`  in  DATA_W, `agen_ldstSize_i`  in  `LDST_TYPES_LOG`, `agen_flags_i`  in  exeFlgs  AGEN_ALU results, same cycle.
- `mem_valid_o`  out  1 / `mem_ready_i`  in  1  output stage handshake.
- `mem_address_o`  out  DATA_W, `mem_size_o`  out  `LDST_TYPES_LOG`, `mem_flags_o`  out  exeFlgs, `mem_tag_o`  out  TAG_W, `mem_is_store_o`  out  1, `mem_stdata_o`  out  DATA_W  registered result.

## Operation
- Slot free: `slot_free = !mem_valid_o || mem_ready_i`. No grant is made when `slot_free=0` or `flush_i=1`.
- Grant rule in state LD_PRI: if the load lane is valid, grant the load; otherwise, if the store lane is valid, grant the store.
- Grant rule in state ST_FORCE: if the store lane is valid, grant the store; otherwise, if the load lane is valid, grant the load.
- Ready outputs: `ld_ready_o` and `st_ready_o` equal the grant of their lane. A transfer occurs when valid and ready are both 1.
- AGEN drive: the AGEN ports carry the granted lane's operands. With no grant they carry the load lane's operands, and the result is discarded.
- Load grant captures: `mem_address_o`, `mem_size_o`, `mem_flags_o` and `mem_tag_o` from the AGEN and load lane; `mem_is_store_o=0`; `mem_stdata_o=0`.
- Store grant captures: the same fields with `mem_is_store_o=1` and `mem_stdata_o=st_data2_i`.
- Hold: while `mem_valid_o=1 && mem_ready_i=0`, all `mem_*` outputs stay stable.
- Starvation FSM, counter `starve_cnt` of width `$clog2(STARVE_LIMIT+1)`:
  - In LD_PRI, the counter increments each cycle that `st_valid_i=1` and the store is not granted, saturating at STARVE_LIMIT.
  - In LD_PRI, when the counter reaches STARVE_LIMIT, the next state is ST_FORCE.
  - ST_FORCE returns to LD_PRI with counter 0 on a store grant, or when `st_valid_i` drops.
  - A store grant in LD_PRI also clears the counter.
- Flush: at the next edge `mem_valid_o` goes to 0, state goes to LD_PRI and the counter goes to 0. Flush wins over `mem_ready_i` and over any new grant.
- Illegal opcode or funct3: the AGEN output is forwarded unchanged. The block does not decode opcodes.

## Timing
- Latency: grant in cycle N, `mem_valid_o=1` in cycle N+1.
- Throughput: one operation per cycle when `mem_ready_i` is held at 1.
- Back-to-back: drain and refill happen in the same cycle; `mem_valid_o` stays at 1.
- Reset values: `mem_valid_o=0`, all `mem_*` data outputs 0, state LD_PRI, counter 0.
- Combinational paths:
  - `ld_ready_o` and `st_ready_o` depend combinationally on `mem_ready_i` and `flush_i`.
  - There is no combinational path from `mem_ready_i` to `mem_valid_o`.
- Reset mid-operation: the held result is lost; no partial handshake survives reset.

## Configuration
- `AGEN_ARB_STARVE_GUARD_EN` defined: the starvation FSM and counter are built as described above.
- `AGEN_ARB_STARVE_GUARD_EN` undefined: strict load priority. The FSM and counter are removed. A store is granted only when `ld_valid_i=0`.

## Test plan
- Reset, then a load with data1=0x1000, immd=-4, LW: next cycle `mem_valid_o=1`, address=0xFFC, size=`LDST_WORD`, `ldSign=1`, `mem_is_store_o=0`.
- Load and store both valid and `mem_ready_i=1` continuously, STARVE_LIMIT=8:
  - Loads are granted for 8 cycles, then the store is granted in cycle 9 with `mem_is_store_o=1` and `mem_stdata_o=st_data2_i`.
  - With the macro off, the store is never granted while loads stay valid.
- `mem_ready_i=0` for 5 cycles while a result is held: both ready outputs stay 0 and the `mem_*` outputs are stable. Raising `mem_ready_i` produces a same-cycle regrant with no bubble.
- `flush_i=1` while valid with `mem_ready_i=1` and a pending load: the load is not granted, `mem_valid_o=0` next cycle, and the counter reads 0.
- Store SD with data1=0x2000, immd=8, data2=0xDEAD: address=0x2008, size=`LDST_DOUBLE_WORD`, `executed=1`, `mem_stdata_o=0xDEAD`.
- `reset_n` asserted asynchronously mid-hold: `mem_valid_o` drops immediately, without waiting for a clock edge, and the state returns to LD_PRI.
